mem_replace_scheduler: RTL and testbench



---
 rtl/mem_replace_scheduler.sv | 165 ++++++++++++++++
 tb/tb_mem_replace_scheduler.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_replace_scheduler.sv
// Queues number-replacement requests and issues them one at a time to mem_manager,
// confirming each write by snooping the received-number stream, with timeout and retry.
module mem_replace_scheduler #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRIES    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_data,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            no_nums,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem_replace_num,
    output logic                             mem_replace_valid,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem_received_num,
    input  logic                             mem_valid,
    output logic                             busy,
    output logic                             done,
    output logic                             err_addr,
    output logic                             err_timeout
);
    localparam int NUM_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(1);
    localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRIES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT
    } state_t;

    logic [NUM_W-1:0]      r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_count;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_curAddr;
    logic [DATA_WIDTH-1:0] r_curData;
    logic [TMR_W-1:0]      r_timer;
    logic [RTY_W-1:0]      r_retry;
    logic                  r_replaceValid;
    logic [NUM_W-1:0]      r_replaceNum;
    logic                  r_done;
    logic                  r_errAddr;
    logic                  r_errTimeout;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_match;

    assign req_ready = !rst && (r_count != FULL_COUNT);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    // A stale echo of the same address with old data must not confirm the write.
    assign w_match   = mem_valid && (mem_received_num == {r_curAddr, r_curData});

    assign mem_replace_valid = r_replaceValid;
    assign mem_replace_num   = r_replaceNum;
    assign done              = r_done;
    assign err_addr          = r_errAddr;
    assign err_timeout       = r_errTimeout;
    assign busy              = (r_count != '0) || (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wrPtr] <= {req_addr, req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Pulses are one cycle wide; the replace strobe is set on entry to ISSUE so it is high exactly there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_curAddr      <= '0;
            r_curData      <= '0;
            r_timer        <= '0;
            r_retry        <= '0;
            r_replaceValid <= 1'b0;
            r_replaceNum   <= '0;
            r_done         <= 1'b0;
            r_errAddr      <= 1'b0;
            r_errTimeout   <= 1'b0;
        end else begin
            r_replaceValid <= 1'b0;
            r_done         <= 1'b0;
            r_errAddr      <= 1'b0;
            r_errTimeout   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_curAddr, r_curData} <= r_fifo[r_rdPtr];
                        r_state                <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_curAddr >= no_nums) begin
                        r_errAddr <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_retry        <= '0;
                        r_replaceValid <= 1'b1;
                        r_replaceNum   <= {r_curAddr, r_curData};
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= TMR_LOAD;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_match) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_timer <= TMR_LAST) begin
                        r_timer <= '0;
                        if (r_retry < RTY_MAX) begin
                            r_retry        <= r_retry + 1'b1;
                            r_replaceValid <= 1'b1;
                            r_state        <= S_ISSUE;
                        end else begin
                            r_errTimeout <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_replace_scheduler.sv
// Randomized self-checking bench for mem_replace_scheduler: a delay-line echo model stands in
// for mem_manager, and expected strobes/pulses are derived from request order and cycle timing rules.
`timescale 1ns/1ps
module tb_mem_replace_scheduler;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NW = AW + DW;
    localparam int DEPTH = 4;
    localparam int TO = 50;
    localparam int MR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] no_nums;
    logic [NW-1:0] mem_replace_num;
    logic          mem_replace_valid;
    logic [NW-1:0] mem_received_num;
    logic          mem_valid;
    logic          busy;
    logic          done;
    logic          err_addr;
    logic          err_timeout;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Event logs filled by the monitor
    int            sCyc[$];
    logic [NW-1:0] sNum[$];
    int            sDelay[$];
    int            dCyc[$];
    int            eaCyc[$];
    int            etCyc[$];
    int            prevStrobe = -100;

    // Echo model: -1 silent, 0 random delay 1..TO, >0 fixed delay
    int            echoMode = -1;
    bit            staleFirst = 1'b0;
    bit            noiseOn = 1'b0;
    int            dueCyc[$];
    logic [NW-1:0] dueNum[$];

    mem_replace_scheduler #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
    ) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
        .no_nums(no_nums),
        .mem_replace_num(mem_replace_num), .mem_replace_valid(mem_replace_valid),
        .mem_received_num(mem_received_num), .mem_valid(mem_valid),
        .busy(busy), .done(done), .err_addr(err_addr), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NW-1:0] mk(input int a, input int d);
        return {AW'(a), DW'(d)};
    endfunction

    // Monitor: sample mid-cycle, log events, schedule echoes for each strobe
    always @(negedge clk) begin
        if (mem_replace_valid === 1'b1) begin
            int d;
            vectors++;
            if (prevStrobe == cyc - 1) begin
                miscompares++;
                $display("[TB] FAIL strobe_gap: strobes at cycles %0d and %0d, required non-consecutive", prevStrobe, cyc);
            end
            prevStrobe = cyc;
            d = (echoMode == 0) ? int'($urandom_range(TO, 1)) : echoMode;
            sCyc.push_back(cyc);
            sNum.push_back(mem_replace_num);
            sDelay.push_back(d);
            if (echoMode >= 0) begin
                if (staleFirst) begin
                    dueCyc.push_back(cyc + d / 2);
                    dueNum.push_back({mem_replace_num[NW-1:DW], DW'(0)});
                end
                dueCyc.push_back(cyc + d);
                dueNum.push_back(mem_replace_num);
            end
        end
        if (done === 1'b1)        dCyc.push_back(cyc);
        if (err_addr === 1'b1)    eaCyc.push_back(cyc);
        if (err_timeout === 1'b1) etCyc.push_back(cyc);
    end

    // Echo driver: delivers scheduled echoes, optional unrelated traffic otherwise
    initial begin
        mem_valid = 1'b0;
        mem_received_num = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            mem_received_num = '0;
            while (dueCyc.size() != 0 && dueCyc[0] < cyc) begin
                void'(dueCyc.pop_front());
                void'(dueNum.pop_front());
            end
            if (dueCyc.size() != 0 && dueCyc[0] == cyc) begin
                mem_valid = 1'b1;
                mem_received_num = dueNum.pop_front();
                void'(dueCyc.pop_front());
            end else if (noiseOn && $urandom_range(3, 0) == 0) begin
                mem_valid = 1'b1;
                mem_received_num = {AW'($urandom_range(255, 240)), DW'($urandom)};
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic resetLog();
        sCyc.delete(); sNum.delete(); sDelay.delete();
        dCyc.delete(); eaCyc.delete(); etCyc.delete();
        dueCyc.delete(); dueNum.delete();
        prevStrobe = -100;
    endtask

    // All tasks below start and end at posedge + #1.
    task automatic pushReq(input int a, input int d, output int acc);
        int guard = 0;
        req_addr = AW'(a);
        req_data = DW'(d);
        req_valid = 1'b1;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            miscompares++;
            $display("[TB] FAIL push_stall: req_ready=%b for %0d cycles, required 1", req_ready, guard);
        end
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || dueCyc.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("[TB] FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int n);
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
        rst = 1'b0;
        resetLog();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_addr = 8'd1; req_data = 16'h55; no_nums = 8'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_ready: got %b, required 0", req_ready);
            end
            if (i > 0) begin
                vectors++;
                if ({busy, done, err_addr, err_timeout, mem_replace_valid} !== 5'b0 || mem_replace_num !== '0) begin
                    miscompares++;
                    $display("[TB] FAIL reset_outputs: busy/done/ea/et/strobe=%b%b%b%b%b num=%h, required all 0",
                             busy, done, err_addr, err_timeout, mem_replace_valid, mem_replace_num);
                end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL release_ready: got %b, required 1", req_ready);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_no_push: busy=%b, required 0", busy);
        end
        @(posedge clk);
        #1;
        resetLog();
    endtask

    task automatic test_single_write();
        int acc;
        no_nums = 8'd5; echoMode = 30; staleFirst = 1'b0; noiseOn = 1'b0;
        resetLog();
        pushReq(4, 1, acc);
        waitIdle(300);
        vectors++;
        if (sCyc.size() != 1 || sNum[0] !== mk(4, 1)) begin
            miscompares++;
            $display("[TB] FAIL single_strobe: %0d strobes, first num=%h, required 1 strobe of %h",
                     sCyc.size(), (sNum.size() != 0) ? sNum[0] : '0, mk(4, 1));
        end else begin
            vectors++;
            if (sCyc[0] != acc + 3) begin
                miscompares++;
                $display("[TB] FAIL single_latency: strobe at %0d, required %0d", sCyc[0], acc + 3);
            end
            vectors++;
            if (dCyc.size() != 1 || dCyc[0] != sCyc[0] + 31) begin
                miscompares++;
                $display("[TB] FAIL single_done: %0d dones, first at %0d, required 1 at %0d",
                         dCyc.size(), (dCyc.size() != 0) ? dCyc[0] : -1, sCyc[0] + 31);
            end
        end
        vectors++;
        if (mem_replace_num !== mk(4, 1)) begin
            miscompares++;
            $display("[TB] FAIL num_hold: got %h, required %h", mem_replace_num, mk(4, 1));
        end
    endtask

    task automatic test_queue_full();
        int acc[6];
        int ad[6] = '{3, 2, 1, 0, 4, 3};
        int dd[6] = '{2, 3, 4, 5, 6, 7};
        no_nums = 8'd5; echoMode = 10; staleFirst = 1'b0; noiseOn = 1'b0;
        resetLog();
        for (int i = 0; i < 6; i++) pushReq(ad[i], dd[i], acc[i]);
        waitIdle(800);
        for (int i = 1; i < 5; i++) begin
            vectors++;
            if (acc[i] != acc[0] + i) begin
                miscompares++;
                $display("[TB] FAIL full_accept%0d: accepted at %0d, required %0d", i, acc[i], acc[0] + i);
            end
        end
        // Sixth push waits for the first request to complete and its slot to drain.
        vectors++;
        if (acc[5] != acc[0] + 3 + 10 + 2) begin
            miscompares++;
            $display("[TB] FAIL full_backpressure: accepted at %0d, required %0d", acc[5], acc[0] + 15);
        end
        vectors++;
        if (sNum.size() != 6 || dCyc.size() != 6) begin
            miscompares++;
            $display("[TB] FAIL full_counts: strobes=%0d dones=%0d, required 6 and 6", sNum.size(), dCyc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (sNum[i] !== mk(ad[i], dd[i])) begin
                    miscompares++;
                    $display("[TB] FAIL full_order%0d: got %h, required %h", i, sNum[i], mk(ad[i], dd[i]));
                end
            end
        end
    endtask

    task automatic test_bad_address();
        int t0, t1, t2;
        no_nums = 8'd5; echoMode = 20; staleFirst = 1'b0; noiseOn = 1'b0;
        resetLog();
        pushReq(7, 9, t0);
        pushReq(5, 1, t1);
        pushReq(1, 4, t2);
        waitIdle(300);
        vectors++;
        if (eaCyc.size() != 2 || eaCyc[0] != t0 + 3 || eaCyc[1] != t0 + 5) begin
            miscompares++;
            $display("[TB] FAIL bad_addr_pulses: %0d pulses (first %0d), required 2 at %0d and %0d",
                     eaCyc.size(), (eaCyc.size() != 0) ? eaCyc[0] : -1, t0 + 3, t0 + 5);
        end
        vectors++;
        if (sNum.size() != 1 || sNum[0] !== mk(1, 4) || sCyc[0] != t0 + 7) begin
            miscompares++;
            $display("[TB] FAIL bad_addr_strobe: %0d strobes, first %h at %0d, required %h at %0d",
                     sNum.size(), (sNum.size() != 0) ? sNum[0] : '0, (sCyc.size() != 0) ? sCyc[0] : -1, mk(1, 4), t0 + 7);
        end
        vectors++;
        if (dCyc.size() != 1 || etCyc.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL bad_addr_done: dones=%0d timeouts=%0d, required 1 and 0", dCyc.size(), etCyc.size());
        end
    endtask

    task automatic test_timeout_retry();
        int acc;
        no_nums = 8'd5; echoMode = -1; staleFirst = 1'b0; noiseOn = 1'b1;
        resetLog();
        pushReq(2, 3, acc);
        waitIdle(400);
        noiseOn = 1'b0;
        vectors++;
        if (sCyc.size() != MR + 1) begin
            miscompares++;
            $display("[TB] FAIL retry_count: %0d strobes, required %0d", sCyc.size(), MR + 1);
        end else begin
            for (int i = 0; i <= MR; i++) begin
                vectors++;
                if (sCyc[i] != acc + 3 + i * (TO + 1) || sNum[i] !== mk(2, 3)) begin
                    miscompares++;
                    $display("[TB] FAIL retry_strobe%0d: %h at %0d, required %h at %0d",
                             i, sNum[i], sCyc[i], mk(2, 3), acc + 3 + i * (TO + 1));
                end
            end
            vectors++;
            if (etCyc.size() != 1 || etCyc[0] != sCyc[MR] + TO + 1) begin
                miscompares++;
                $display("[TB] FAIL err_timeout: %0d pulses (first %0d), required 1 at %0d",
                         etCyc.size(), (etCyc.size() != 0) ? etCyc[0] : -1, sCyc[MR] + TO + 1);
            end
        end
        vectors++;
        if (dCyc.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL timeout_done: %0d done pulses, required 0", dCyc.size());
        end
    endtask

    // Echo on the last waiting cycle: the match beats counter expiry.
    task automatic test_match_at_expiry();
        int acc;
        no_nums = 8'd5; echoMode = TO; staleFirst = 1'b0; noiseOn = 1'b0;
        resetLog();
        pushReq(3, 9, acc);
        waitIdle(300);
        vectors++;
        if (sCyc.size() != 1 || dCyc.size() != 1 || etCyc.size() != 0 || dCyc[0] != sCyc[0] + TO + 1) begin
            miscompares++;
            $display("[TB] FAIL match_at_expiry: strobes=%0d dones=%0d timeouts=%0d, required 1/1/0 with done at strobe+%0d",
                     sCyc.size(), dCyc.size(), etCyc.size(), TO + 1);
        end
    endtask

    task automatic test_stale_and_reset();
        int acc;
        int n;
        no_nums = 8'd5; echoMode = 40; staleFirst = 1'b1; noiseOn = 1'b0;
        resetLog();
        pushReq(2, 3, acc);
        waitIdle(300);
        vectors++;
        if (sCyc.size() != 1 || dCyc.size() != 1 || dCyc[0] != sCyc[0] + 41) begin
            miscompares++;
            $display("[TB] FAIL stale_echo: strobes=%0d dones=%0d (first %0d), required 1 strobe, done at strobe+41",
                     sCyc.size(), dCyc.size(), (dCyc.size() != 0) ? dCyc[0] : -1);
        end
        staleFirst = 1'b0; echoMode = -1;
        resetLog();
        pushReq(2, 3, acc);
        pushReq(1, 1, acc);
        n = 0;
        while (sCyc.size() == 0 && n < 50) begin @(posedge clk); #1; n++; end
        vectors++;
        if (sCyc.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_strobe: no strobe within %0d cycles, required 1", n);
        end
        repeat (10) begin @(posedge clk); #1; end
        applyReset(2);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_busy: got %b, required 0", busy);
        end
        repeat (200) begin @(posedge clk); #1; end
        vectors++;
        if (sCyc.size() + dCyc.size() + eaCyc.size() + etCyc.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_quiet: strobes=%0d dones=%0d ea=%0d et=%0d, required all 0",
                     sCyc.size(), dCyc.size(), eaCyc.size(), etCyc.size());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            logic [NW-1:0] expNum[$];
            int            expBad;
            int            acc;
            int            a;
            int            d;
            int            nn;
            nn = (r == 0) ? 0 : int'($urandom_range(12, 1));
            no_nums = AW'(nn); echoMode = 0; staleFirst = 1'b0; noiseOn = 1'b1;
            expBad = 0;
            resetLog();
            for (int i = 0; i < 8; i++) begin
                a = int'($urandom_range(15, 0));
                d = int'($urandom_range(16'hFFFF, 1));
                if (a < nn) expNum.push_back(mk(a, d));
                else expBad++;
                pushReq(a, d, acc);
                repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
            end
            waitIdle(1200);
            noiseOn = 1'b0;
            vectors++;
            if (sNum.size() != expNum.size() || dCyc.size() != expNum.size() || eaCyc.size() != expBad || etCyc.size() != 0) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_counts: strobes=%0d dones=%0d ea=%0d et=%0d, required %0d/%0d/%0d/0",
                         r, sNum.size(), dCyc.size(), eaCyc.size(), etCyc.size(), expNum.size(), expNum.size(), expBad);
            end else begin
                for (int i = 0; i < expNum.size(); i++) begin
                    vectors++;
                    if (sNum[i] !== expNum[i] || dCyc[i] != sCyc[i] + sDelay[i] + 1) begin
                        miscompares++;
                        $display("[TB] FAIL rand%0d_req%0d: %h done at %0d, required %h done at %0d",
                                 r, i, sNum[i], dCyc[i], expNum[i], sCyc[i] + sDelay[i] + 1);
                    end
                end
            end
        end
    endtask

    initial begin
        req_valid = 1'b0; req_addr = '0; req_data = '0; no_nums = '0; rst = 1'b1;
        test_reset();
        test_single_write();
        test_queue_full();
        test_bad_address();
        test_timeout_retry();
        test_match_at_expiry();
        test_stale_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
